// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - 3x3 window sequencer for line-buffered convolution (optional abort: CONV_SEQ_ABORT_EN)
module conv_window_sequencer #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pix_in_valid,
  input  logic [PIX_W-1:0]         pix_in_data,
  output logic                     pix_in_ready,
  output logic                     lb_wr_en,
  output logic [$clog2(IMG_W)-1:0] lb_wr_addr,
  output logic [PIX_W-1:0]         lb_wr_data,
  output logic [1:0]               lb_sel,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic                     busy,
  output logic                     frame_done
`ifdef CONV_SEQ_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_hit;
  logic          abort_hit;

`ifdef CONV_SEQ_ABORT_EN
  assign abort_hit = abort & (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // A pixel is only taken while running and while no window is stuck at the output
  assign pix_in_ready = (state == RUN) & (~win_valid | win_ready);
  assign accept       = pix_in_valid & pix_in_ready;
  assign col_last     = (col == CW'(IMG_W - 1));
  assign row_last     = (row == RW'(IMG_H - 1));
  assign win_hit      = accept & (row >= RW'(2)) & (col >= CW'(2));

  assign lb_wr_en     = accept;
  assign lb_wr_addr   = col;
  assign lb_wr_data   = pix_in_data;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && col_last && row_last) state_nxt = DRAIN;
      DRAIN:   if (!win_valid || win_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // Raster position and line-buffer bank rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      lb_sel <= 2'd0;
    end else if (abort_hit || (state == IDLE && start)) begin
      col    <= '0;
      row    <= '0;
      lb_sel <= 2'd0;
    end else if (accept) begin
      if (col_last) begin
        col    <= '0;
        row    <= row_last ? '0 : row + RW'(1);
        lb_sel <= (lb_sel == 2'd2) ? 2'd0 : lb_sel + 2'd1;
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window handshake: coordinates load only when a new window arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else if (abort_hit) begin
      win_valid <= 1'b0;
    end else if (win_hit) begin
      win_valid <= 1'b1;
      win_col   <= col - CW'(1);
      win_row   <= row - RW'(1);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - scoreboard bench for conv_window_sequencer (IMG_W=4, IMG_H=3)
module tb_conv_window_sequencer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int PIX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             pix_in_valid = 1'b0;
  logic [PIX_W-1:0] pix_in_data = '0;
  logic             pix_in_ready;
  logic             lb_wr_en;
  logic [1:0]       lb_wr_addr;
  logic [PIX_W-1:0] lb_wr_data;
  logic [1:0]       lb_sel;
  logic             win_valid;
  logic             win_ready = 1'b1;
  logic [1:0]       win_col;
  logic [1:0]       win_row;
  logic             busy;
  logic             frame_done;
`ifdef CONV_SEQ_ABORT_EN
  logic             abort = 1'b0;
`endif

  conv_window_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_in_valid(pix_in_valid), .pix_in_data(pix_in_data), .pix_in_ready(pix_in_ready),
    .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data), .lb_sel(lb_sel),
    .win_valid(win_valid), .win_ready(win_ready), .win_col(win_col), .win_row(win_row),
    .busy(busy), .frame_done(frame_done)
`ifdef CONV_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;
  int win_pops = 0;

  int wq_addr[$];
  int wq_sel[$];
  int wq_data[$];
  int winq_row[$];
  int winq_col[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: line-buffer writes, window handshakes and frame_done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (lb_wr_en) begin
        if (wq_addr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("wr_addr", int'(lb_wr_addr), wq_addr.pop_front());
          chk("wr_sel",  int'(lb_sel),     wq_sel.pop_front());
          chk("wr_data", int'(lb_wr_data), wq_data.pop_front());
        end
      end
      if (win_valid && win_ready) begin
        win_pops++;
        if (winq_row.size() == 0) begin
          chk("unexpected_window", 1, 0);
        end else begin
          chk("win_row", int'(win_row), winq_row.pop_front());
          chk("win_col", int'(win_col), winq_col.pop_front());
        end
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic flush_queues();
    wq_addr.delete(); wq_sel.delete(); wq_data.delete();
    winq_row.delete(); winq_col.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Drive pixels idx = first .. first+n-1 of the raster; expectations pushed before each is offered
  task automatic send_pixels(input int first, input int n);
    int idx, r, c, t;
    for (int k = 0; k < n; k++) begin
      idx = first + k;
      r = idx / IMG_W;
      c = idx % IMG_W;
      wq_addr.push_back(c);
      wq_sel.push_back(r % 3);
      wq_data.push_back((idx * 7 + 3) & 8'hff);
      if (r >= 2 && c >= 2) begin
        winq_row.push_back(r - 1);
        winq_col.push_back(c - 1);
      end
      pix_in_valid = 1'b1;
      pix_in_data  = 8'((idx * 7 + 3) & 8'hff);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!pix_in_ready && t < 200);
      if (!pix_in_ready) begin
        chk("accept_timeout", 0, 1);
        pix_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    pix_in_valid = 1'b0;
  endtask

  int fd0, wp0, t;

  initial begin
    // 1: reset state and idle with valid asserted
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_lb_sel", lb_sel, 0);
    chk("rst_addr", lb_wr_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    pix_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", pix_in_ready, 0);
      chk("idle_wr_en", lb_wr_en, 0);
      chk("idle_busy", busy, 0);
    end
    @(posedge clk); #1 pix_in_valid = 1'b0;

    // 2: full frame, frame_done timing after drain
    fd0 = fd_count; wp0 = win_pops;
    win_ready = 1'b1;
    pulse_start();
    send_pixels(0, 12);
    @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_fd", frame_done, 0);
    @(negedge clk);
    chk("done_fd", frame_done, 1);
    @(negedge clk);
    chk("after_fd", frame_done, 0);
    chk("after_busy", busy, 0);
    chk("f2_frames", fd_count - fd0, 1);
    chk("f2_windows", win_pops - wp0, 2);
    chk("f2_winq_empty", winq_row.size(), 0);
    chk("f2_wq_empty", wq_addr.size(), 0);

    // 3: window backpressure stalls the pixel stream
    fd0 = fd_count; wp0 = win_pops;
    win_ready = 1'b0;
    pulse_start();
    fork
      send_pixels(0, 12);
      begin
        t = 0;
        while (!win_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        chk("stall_win_seen", win_valid, 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_ready", pix_in_ready, 0);
          chk("stall_win_col", win_col, 1);
          chk("stall_win_row", win_row, 1);
          chk("stall_win_valid", win_valid, 1);
        end
        @(posedge clk); #1 win_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("f3_frames", fd_count - fd0, 1);
    chk("f3_windows", win_pops - wp0, 2);
    chk("f3_wq_empty", wq_addr.size(), 0);
    chk("f3_busy", busy, 0);

    // 4: start during RUN is ignored
    fd0 = fd_count; wp0 = win_pops;
    pulse_start();
    send_pixels(0, 5);
    pulse_start();
    @(negedge clk);
    chk("rerun_busy", busy, 1);
    chk("rerun_addr", lb_wr_addr, 1);
    chk("rerun_sel", lb_sel, 1);
    @(posedge clk); #1;
    send_pixels(5, 7);
    repeat (10) @(negedge clk);
    chk("f4_frames", fd_count - fd0, 1);
    chk("f4_windows", win_pops - wp0, 2);
    chk("f4_wq_empty", wq_addr.size(), 0);

    // 5: asynchronous reset mid-frame, then a clean frame
    fd0 = fd_count;
    pulse_start();
    send_pixels(0, 7);
    rst_n = 1'b0;
    #2;
    chk("arst_busy", busy, 0);
    chk("arst_ready", pix_in_ready, 0);
    chk("arst_addr", lb_wr_addr, 0);
    chk("arst_sel", lb_sel, 0);
    chk("arst_win_valid", win_valid, 0);
    chk("arst_fd", frame_done, 0);
    flush_queues();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    chk("arst_no_fd", fd_count - fd0, 0);
    fd0 = fd_count; wp0 = win_pops;
    pulse_start();
    send_pixels(0, 12);
    repeat (10) @(negedge clk);
    chk("f5_frames", fd_count - fd0, 1);
    chk("f5_windows", win_pops - wp0, 2);
    chk("f5_wq_empty", wq_addr.size(), 0);

`ifdef CONV_SEQ_ABORT_EN
    // 6: abort with a pending window
    fd0 = fd_count;
    win_ready = 1'b0;
    pulse_start();
    send_pixels(0, 11);
    @(negedge clk);
    chk("abort_pre_win", win_valid, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_win_valid", win_valid, 0);
    chk("abort_addr", lb_wr_addr, 0);
    chk("abort_sel", lb_sel, 0);
    flush_queues();
    win_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_fd", fd_count - fd0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
